instr_fetch_decode: RTL
=======================

# instr_fetch_decode

Instruction fetch/decode unit: the reading end of the program RAM interface. The testbench loads instruction words into RAM; this block reads them back sequentially starting at a program counter. It splits each word into the CPU's instruction fields and presents them, with a valid/ready handshake, to the register bank, ALU and memory control. It owns the RAM port only while fetching: it drives Enable/Address with RW held at read.

## Interface
- ADDR_W, 16, RAM address / PC width
- RAM_LATENCY, 1, cycles from Enable+Address to valid Out (1..7)
- HALT_WORD, 32'hFFFFFFFF, fetched word that stops fetching; never presented
- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  pulse; begin fetching at Start_Addr (ignored unless IDLE)
- Start_Addr  in  ADDR_W  first fetch address
- Load_PC  in  1  redirect request (ignored in IDLE)
- New_PC  in  ADDR_W  redirect target
- Enable  out  1  RAM enable
- RW  out  1  RAM direction; constant 0 (read)
- Address  out  ADDR_W  RAM address
- Out  in  32  RAM read data
- Instr_Valid  out  1  decoded instruction available
- Instr_Ready  in  1  consumer accepts instruction
- instruction  out  32  raw word
- Instr_Addr  out  ADDR_W  address the word came from
- Cond  out  4  instruction[31:28]
- OpCode  out  4  instruction[27:24]
- S  out  1  instruction[23]
- destination  out  4  instruction[22:19]
- source_2  out  4  instruction[18:15]
- source_1  out  4  instruction[14:11]
- IV  out  5  instruction[10:6]
- Busy  out  1  state != IDLE
- Halted  out  1  one-cycle pulse when HALT_WORD is fetched

## Operation
- States: IDLE, FETCH, PRESENT.
- IDLE: Enable=0, Instr_Valid=0. On Start, PC<=Start_Addr and go to FETCH.
- FETCH: Enable=1, Address=PC, latency counter runs 0..RAM_LATENCY-1. On the edge where the counter equals RAM_LATENCY-1:
  - if Out==HALT_WORD, pulse Halted and go to IDLE; PC is unchanged.
  - otherwise capture Out into instruction, PC into Instr_Addr, set PC<=PC+1 (wraps modulo 2^ADDR_W), and go to PRESENT.
- PRESENT: Enable=0, Instr_Valid=1. All field outputs and Instr_Addr are held stable until Instr_Ready=1 at a clock edge, then go to FETCH.
- Field outputs are combinational slices of the registered instruction.
- Load_PC (FETCH or PRESENT): at that edge, PC<=New_PC, the latency counter clears, any held instruction is dropped, and the next state is FETCH. Load_PC takes priority over capture and over halt detection in the same cycle.
- Load_PC together with Instr_Valid&Instr_Ready: the handshake counts as completed (the consumer keeps the word), and fetch resumes at New_PC.
- Start while Busy, and Load_PC in IDLE: ignored.
- Reset (asynchronous, any state, mid-fetch included): state=IDLE, PC=0, counter=0. All outputs are 0: Enable, RW, Address, Instr_Valid, instruction, Instr_Addr, all fields, Busy, Halted.

## Timing
- Start at edge k -> Enable=1 with Address=Start_Addr during cycle k+1.
- First Instr_Valid in cycle k+1+RAM_LATENCY.
- Handshake at edge h -> next Enable in cycle h+1 at Address=previous+1.
- Steady-state throughput with Instr_Ready held high: one instruction per RAM_LATENCY+1 cycles.
- Enable and Address change only on clock edges; Address is stable for all RAM_LATENCY cycles of a fetch.
- Halted rises in the cycle after HALT_WORD is sampled. It coincides with the first IDLE cycle and lasts exactly one cycle.
- PC wrap: a fetch at Address=16'hFFFF is followed by a fetch at 16'h0000.

## Test plan
- Reset/idle: hold Reset=0 while Start is pulsed -> all outputs 0. Release Reset without Start -> Enable stays 0 indefinitely.
- Sequential fetch: RAM[0..2]=AAAAAAAA, ABBBAAAA, CCCC00AA; Start_Addr=0; Instr_Ready=1 -> three instructions in order.
  - Word 1 (Instr_Addr=0): Cond=A, OpCode=A, S=1, destination=5, source_2=5, source_1=5, IV=0A.
  - Word 2: OpCode=B, Cond=A. Word 3: Cond=C.
  - Spacing is 2 cycles apart (RAM_LATENCY=1).
- Backpressure: Instr_Ready=0 for 5 cycles on word 0x0001 -> Instr_Valid and fields stable and Enable=0 for those cycles; the next fetch at 0x0002 starts one cycle after Instr_Ready=1.
- Halt: RAM[3]=FFFFFFFF -> after word 2 is accepted, Halted pulses for one cycle, Busy=0, and Instr_Valid never asserts for address 3.
- Redirect: Load_PC=1 with New_PC=0x0010 while in PRESENT with Instr_Ready=0 -> the held word is dropped, the next Enable is at Address=0x0010, and the next Instr_Addr is 0x0010. Repeat with Instr_Ready=1 in the same cycle -> the word is consumed and fetch goes to 0x0010.
- Wrap and async reset: Start_Addr=16'hFFFF -> fetches at FFFF, then 0000. Assert Reset mid-FETCH (between edges) -> Enable drops to 0 immediately and the state is IDLE.

Source files
------------

// File: rtl/instr_fetch_decode.sv
// instr_fetch_decode: sequential RAM instruction fetch with field decode and valid/ready handoff
module instr_fetch_decode #(
   parameter int          ADDR_W      = 16,
   parameter int          RAM_LATENCY = 1,
   parameter logic [31:0] HALT_WORD   = 32'hFFFFFFFF
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Start,
   input  logic [ADDR_W-1:0] Start_Addr,
   input  logic              Load_PC,
   input  logic [ADDR_W-1:0] New_PC,
   output logic              Enable,
   output logic              RW,
   output logic [ADDR_W-1:0] Address,
   input  logic [31:0]       Out,
   output logic              Instr_Valid,
   input  logic              Instr_Ready,
   output logic [31:0]       instruction,
   output logic [ADDR_W-1:0] Instr_Addr,
   output logic [3:0]        Cond,
   output logic [3:0]        OpCode,
   output logic              S,
   output logic [3:0]        destination,
   output logic [3:0]        source_2,
   output logic [3:0]        source_1,
   output logic [4:0]        IV,
   output logic              Busy,
   output logic              Halted
);
   typedef enum logic [1:0] {IDLE, FETCH, PRESENT} state_t;
   localparam logic [2:0] LAST = 3'(RAM_LATENCY - 1);
   state_t state, state_d;
   logic [ADDR_W-1:0] pc, instr_addr;
   logic [2:0] cnt;
   logic [31:0] instr;
   logic halted, last, halt_hit, capture;
   assign last     = cnt == LAST;
   // a redirect in the same cycle overrides both capture and halt detection
   assign halt_hit = state == FETCH && !Load_PC && last && Out == HALT_WORD;
   assign capture  = state == FETCH && !Load_PC && last && Out != HALT_WORD;
   always_comb begin
      state_d = state;
      unique case (state)
         IDLE:    state_d = Start ? FETCH : IDLE;
         FETCH:   state_d = halt_hit ? IDLE : capture ? PRESENT : FETCH;
         PRESENT: state_d = (Load_PC || Instr_Ready) ? FETCH : PRESENT;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state      <= IDLE;
         pc         <= '0;
         cnt        <= '0;
         instr      <= '0;
         instr_addr <= '0;
         halted     <= 1'b0;
      end else begin
         state  <= state_d;
         halted <= halt_hit;
         cnt    <= (state == FETCH && !Load_PC && !last) ? cnt + 3'd1 : 3'd0;
         if (state == IDLE && Start) pc <= Start_Addr;
         else if (state != IDLE && Load_PC) pc <= New_PC;
         else if (capture) pc <= pc + ADDR_W'(1);
         if (capture) begin
            instr      <= Out;
            instr_addr <= pc;
         end
      end
   end
   assign Enable      = state == FETCH;
   assign RW          = 1'b0;
   assign Address     = Enable ? pc : '0;
   assign Instr_Valid = state == PRESENT;
   assign Busy        = state != IDLE;
   assign Halted      = halted;
   assign instruction = instr;
   assign Instr_Addr  = instr_addr;
   assign Cond        = instr[31:28];
   assign OpCode      = instr[27:24];
   assign S           = instr[23];
   assign destination = instr[22:19];
   assign source_2    = instr[18:15];
   assign source_1    = instr[14:11];
   assign IV          = instr[10:6];
endmodule
